// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O controller that sits between the CPU MEM
// stage and the board-facing signals. It decodes io bus loads and stores in
// the 0xFFxx window (io_addr is the low byte).
//
// Register map:
//   0x00  LED register; writable, reads {16'b0, led}
//   0x04  switch-entry ready flag (in_rdy); read-only
//   0x08  segment output ready (~seg_busy); read-only
//   0x0C  segment data; a write is accepted only when not busy
//   0x10  latched switches; a load here clears in_rdy
//   0x14  free-running 32-bit cycle counter
//   0x18  live synchronized switches
//
// Debounce FSM:
//   state  | meaning
//   S_LOW  | button settled released
//   S_RISE | saw a high sample, counting stable highs
//   S_HIGH | button settled pressed (the press pulse was emitted on entry)
//   S_FALL | saw a low sample, counting stable lows
//
// Ports:
//   clk, rst           system clock, synchronous active-low reset
//   io_addr/io_dout    CPU register offset and store data
//   io_we/io_rd        one-cycle store / load strobes
//   io_din             combinational load data
//   btn, sw            raw asynchronous button and switches
//   led                LED register
//   seg_data/seg_busy  segment value and hold-busy flag
module mmio_io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter int SW_W            = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      io_addr,
  input  logic [31:0]     io_dout,
  input  logic            io_we,
  input  logic            io_rd,
  output logic [31:0]     io_din,
  input  logic            btn,
  input  logic [SW_W-1:0] sw,
  output logic [15:0]     led,
  output logic [31:0]     seg_data,
  output logic            seg_busy
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

  localparam logic [7:0] A_LED  = 8'h00;
  localparam logic [7:0] A_IRDY = 8'h04;
  localparam logic [7:0] A_ORDY = 8'h08;
  localparam logic [7:0] A_SEG  = 8'h0C;
  localparam logic [7:0] A_SWL  = 8'h10;
  localparam logic [7:0] A_CNT  = 8'h14;
  localparam logic [7:0] A_SWS  = 8'h18;

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} db_state_t;

  db_state_t         state, state_nxt;
  logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
  logic              press;
  logic              btn_m, btn_s;
  logic [SW_W-1:0]   sw_m, sw_s;
  logic [SW_W-1:0]   sw_latch;
  logic              in_rdy;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       cycle_cnt;

  // Two-flop synchronizers; nothing downstream sees the raw pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      sw_m  <= sw;
      sw_s  <= sw_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_LOW;
      db_cnt <= '0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    press      = 1'b0;
    unique case (state)
      S_LOW: if (btn_s) begin
        state_nxt  = S_RISE;
        db_cnt_nxt = '0;
      end
      S_RISE: begin
        if (!btn_s) begin
          state_nxt = S_LOW;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_nxt = S_HIGH;
          press     = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      S_HIGH: if (!btn_s) begin
        state_nxt  = S_FALL;
        db_cnt_nxt = '0;
      end
      S_FALL: begin
        if (btn_s) begin
          state_nxt = S_HIGH;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_nxt = S_LOW;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      default: state_nxt = S_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led       <= '0;
      seg_data  <= '0;
      seg_busy  <= 1'b0;
      hold_cnt  <= '0;
      in_rdy    <= 1'b0;
      sw_latch  <= '0;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;

      if (io_we && io_addr == A_LED) led <= io_dout[15:0];

      // A store while busy is dropped so the held value is never disturbed.
      if (seg_busy) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) seg_busy <= 1'b0;
      end else if (io_we && io_addr == A_SEG) begin
        seg_data <= io_dout;
        seg_busy <= 1'b1;
        hold_cnt <= '0;
      end

      // A press in the same cycle as the consuming load wins: the new entry
      // must not be lost.
      if (press) begin
        sw_latch <= sw_s;
        in_rdy   <= 1'b1;
      end else if (io_rd && io_addr == A_SWL) begin
        in_rdy <= 1'b0;
      end
    end
  end

  always_comb begin
    io_din = '0;
    unique case (io_addr)
      A_LED:   io_din = {16'b0, led};
      A_IRDY:  io_din = {31'b0, in_rdy};
      A_ORDY:  io_din = {31'b0, ~seg_busy};
      A_SEG:   io_din = seg_data;
      A_SWL:   io_din = 32'(sw_latch);
      A_CNT:   io_din = cycle_cnt;
      A_SWS:   io_din = 32'(sw_s);
      default: io_din = '0;
    endcase
  end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
Memory-mapped peripheral controller on the CPU io bus (io_addr/io_dout/io_we/io_rd/io_din). It decodes CPU loads and stores to the 0xFFxx window and serves LED output, a handshaked switch-entry input and a handshaked seven-segment output. It also provides a debounced button FSM and a free-running cycle counter. It sits between the CPU's MEM stage and the board-facing PDU signals.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a button level change; board builds set 1000000.
HOLD_CYCLES, 8, cycles the segment output stays busy after an accepted write.
SW_W, 16, switch input width.

Ports:
clk  in  1  system clock
rst  in  1  reset
io_addr  in  8  word-aligned register offset from CPU
io_dout  in  32  CPU store data
io_we  in  1  CPU store strobe, one cycle per store
io_rd  in  1  CPU load strobe, one cycle per load
io_din  out  32  load data to CPU, combinational from io_addr
btn  in  1  raw asynchronous push button
sw  in  SW_W  raw asynchronous switches
led  out  16  LED register
seg_data  out  32  segment display value
seg_busy  out  1  high while a segment write is being held

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst). While rst=0 at a rising edge, all state clears:
  - led=0, seg_data=0, seg_busy=0.
  - in_rdy=0, sw_latch=0, cycle counter=0.
  - Debounce FSM returns to LOW with its counter at 0.
  - Synchronizer flops are cleared.
  - Reset asserted mid-hold or mid-debounce aborts the operation.
- Synchronizers: btn and sw each pass through 2 flops (btn_s, sw_s). Raw inputs are never used directly.
- Register map (io_addr, reads via io_din, writes on io_we at clk edge):
  - 0x00 W: led <= io_dout[15:0]. Reads return {16'b0, led}.
  - 0x04 R: {31'b0, in_rdy}.
  - 0x08 R: {31'b0, ~seg_busy} (output ready).
  - 0x0C W: if seg_busy=0, then seg_data <= io_dout, seg_busy <= 1, and hold_cnt <= 0. If seg_busy=1, the write is ignored (no restart, data kept). Reads return seg_data.
  - 0x10 R: {zero-ext, sw_latch}. io_rd=1 at this address clears in_rdy at the edge.
  - 0x14 R: cycle counter. 32-bit, +1 every cycle, wraps 0xFFFFFFFF->0.
  - 0x18 R: {zero-ext, sw_s}, the live synchronized switches.
  - Any other address: reads return 0; writes are ignored.
- io_din is purely combinational from io_addr and current state. It does not depend on io_rd. Read side effects occur only when io_rd=1.
- io_we and io_rd both high: the write is performed, read data is still driven, and side effects of both apply.
- Debounce FSM on btn_s, states LOW, RISE, HIGH, FALL:
  - LOW: btn_s=1 -> RISE, cnt=0.
  - RISE: if btn_s=0 -> LOW. Otherwise cnt+1; at cnt==DEBOUNCE_CYCLES-1 -> HIGH and emit a one-cycle press pulse.
  - HIGH: btn_s=0 -> FALL, cnt=0.
  - FALL: if btn_s=1 -> HIGH. Otherwise cnt+1; at cnt==DEBOUNCE_CYCLES-1 -> LOW.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- Press pulse: sw_latch <= sw_s and in_rdy <= 1. A pulse arriving while in_rdy=1 overwrites sw_latch (last press wins).
- Press pulse and a 0x10 read in the same cycle: the set wins. in_rdy stays 1 and sw_latch takes the new value; the read returns the old value.
- Latency: a clean raw btn rise before edge 0 gives the press pulse at edge DEBOUNCE_CYCLES+2 and in_rdy high after it.
- Hold counter: while seg_busy=1, hold_cnt+1 each cycle. seg_busy falls at the edge where hold_cnt==HOLD_CYCLES-1, giving exactly HOLD_CYCLES busy cycles.
- Counter widths: DEBOUNCE and HOLD counters are sized $clog2(param)+1 and never wrap in normal operation.

Test Plan:
- Reset: hold rst=0 for 3 cycles with btn=1 and sw=16'hFFFF, then release -> led=0, seg_busy=0, read 0x04 returns 0, read 0x14 returns 0 on the first cycle after release.
- LED write: io_we, addr 0x00, io_dout=32'hABCD1234 -> led=16'h1234 next cycle; read 0x00 returns 32'h00001234; a write to 0x3C leaves led unchanged.
- Segment handshake: write 0x0C with 32'h00000042 -> seg_busy=1 for exactly 8 cycles and 0x08 reads 0 during them. A second write of 32'h99 at busy cycle 3 is ignored (seg_data stays 0x42). 0x08 reads 1 after.
- Button debounce: set sw=16'h00A5, pulse btn high for 10 cycles -> no in_rdy. Then hold btn high for 30 cycles -> in_rdy=1 at cycle 18 after the rise; read 0x10 returns 0x000000A5 and in_rdy=0 the next cycle.
- Collision: hold in_rdy=1 with sw_latch=0x00A5, then make a new press pulse (sw=0x005A) coincide with an io_rd of 0x10 -> read returns 0xA5, in_rdy stays 1, next 0x10 read returns 0x5A.
- Counter wrap: force the counter to 32'hFFFFFFFE -> reads 0xFFFFFFFF then 0x00000000 on consecutive cycles; reset mid-count clears it to 0.
